// File: rtl/bomb_manager.sv
// bomb_manager: owns six bomb slots (0-2 P1, 3-5 P2) plus both players' life counts.
// Latency: placement ack, slot and lives updates land one cycle after the request/tick; read port is combinational.
// Backpressure: none; a rejected placement is dropped with no ack and no queuing.
//
// Ports:
//   clock, reset (async, active-high), game_reset (sync round clear, overrides all)
//   refresh            one-cycle frame tick driving fuse/blast counts and damage
//   p1_place/x/y, p2_place/x/y   placement requests at the player's tile
//   bomb_id            read select -> bomb_active, bomb_exploding, bomb_x, bomb_y (ids 6,7 read 0)
//   p1_ack, p2_ack     registered accept pulses
//   p1_lives, p2_lives 3..0, any zero freezes the round until game_reset
module bomb_manager #(
  parameter int FUSE_TICKS  = 12,
  parameter int BLAST_TICKS = 4,
  parameter int RADIUS      = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       game_reset,
  input  logic       refresh,
  input  logic       p1_place,
  input  logic [3:0] p1_x,
  input  logic [3:0] p1_y,
  input  logic       p2_place,
  input  logic [3:0] p2_x,
  input  logic [3:0] p2_y,
  input  logic [2:0] bomb_id,
  output logic       bomb_active,
  output logic       bomb_exploding,
  output logic [3:0] bomb_x,
  output logic [3:0] bomb_y,
  output logic       p1_ack,
  output logic       p2_ack,
  output logic [1:0] p1_lives,
  output logic [1:0] p2_lives
);

  localparam int         NUM_SLOTS = 6;
  localparam logic [3:0] FUSE_CNT  = 4'(FUSE_TICKS);
  localparam logic [3:0] BLAST_CNT = 4'(BLAST_TICKS);
  localparam logic [4:0] RADIUS_W  = 5'(RADIUS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FUSE  = 2'd1,
    S_BLAST = 2'd2
  } slot_state_t;

  slot_state_t state_q [NUM_SLOTS];
  slot_state_t state_d [NUM_SLOTS];
  logic [3:0]  x_q     [NUM_SLOTS];
  logic [3:0]  x_d     [NUM_SLOTS];
  logic [3:0]  y_q     [NUM_SLOTS];
  logic [3:0]  y_d     [NUM_SLOTS];
  logic [3:0]  cnt_q   [NUM_SLOTS];
  logic [3:0]  cnt_d   [NUM_SLOTS];

  logic [1:0] p1_lives_q, p1_lives_d;
  logic [1:0] p2_lives_q, p2_lives_d;
  logic       p1_ack_q, p1_ack_d;
  logic       p2_ack_q, p2_ack_d;

  logic       frozen;
  logic       tick;
  logic       p1_busy, p2_busy;
  logic       p1_free, p2_free;
  logic [2:0] p1_slot, p2_slot;
  logic       same_tile;
  logic       p1_accept, p2_accept;
  logic       p1_hit, p2_hit;

  // Cross-shaped blast: same column within RADIUS rows, or same row within RADIUS columns.
  // Differences are taken in 5-bit signed so tiles near 0 or 15 never wrap.
  function automatic logic covers(input logic [3:0] bx, input logic [3:0] by,
                                  input logic [3:0] tx, input logic [3:0] ty);
    logic signed [4:0] dx;
    logic signed [4:0] dy;
    logic [4:0]        adx;
    logic [4:0]        ady;
    dx  = $signed({1'b0, tx}) - $signed({1'b0, bx});
    dy  = $signed({1'b0, ty}) - $signed({1'b0, by});
    adx = dx[4] ? $unsigned(-dx) : $unsigned(dx);
    ady = dy[4] ? $unsigned(-dy) : $unsigned(dy);
    return ((tx == bx) && (ady <= RADIUS_W)) || ((ty == by) && (adx <= RADIUS_W));
  endfunction

  // Placement decisions look only at registered slot state.
  always_comb begin
    frozen  = (p1_lives_q == 2'd0) || (p2_lives_q == 2'd0);
    tick    = refresh && !frozen;
    p1_busy = 1'b0;
    p2_busy = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (state_q[i] != S_IDLE) begin
        if ((x_q[i] == p1_x) && (y_q[i] == p1_y)) p1_busy = 1'b1;
        if ((x_q[i] == p2_x) && (y_q[i] == p2_y)) p2_busy = 1'b1;
      end
    end
    // Scan downwards so the lowest-index idle slot is the one left selected.
    p1_free = 1'b0;
    p1_slot = 3'd0;
    for (int i = 2; i >= 0; i--) begin
      if (state_q[i] == S_IDLE) begin
        p1_free = 1'b1;
        p1_slot = 3'(i);
      end
    end
    p2_free = 1'b0;
    p2_slot = 3'd3;
    for (int i = 5; i >= 3; i--) begin
      if (state_q[i] == S_IDLE) begin
        p2_free = 1'b1;
        p2_slot = 3'(i);
      end
    end
    // P1 has priority on a shared tile requested in the same cycle.
    same_tile = p1_place && (p1_x == p2_x) && (p1_y == p2_y);
    p1_accept = p1_place && !frozen && p1_free && !p1_busy;
    p2_accept = p2_place && !frozen && p2_free && !p2_busy && !same_tile;
  end

  always_comb begin
    p1_hit = 1'b0;
    p2_hit = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      state_d[i] = state_q[i];
      x_d[i]     = x_q[i];
      y_d[i]     = y_q[i];
      cnt_d[i]   = cnt_q[i];
    end

    if (tick) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        case (state_q[i])
          S_FUSE: begin
            if (cnt_q[i] > 4'd1) begin
              cnt_d[i] = cnt_q[i] - 4'd1;
            end else begin
              // Detonating this tick: only these slots deal damage.
              state_d[i] = S_BLAST;
              cnt_d[i]   = BLAST_CNT;
              if (covers(x_q[i], y_q[i], p1_x, p1_y)) p1_hit = 1'b1;
              if (covers(x_q[i], y_q[i], p2_x, p2_y)) p2_hit = 1'b1;
            end
          end
          S_BLAST: begin
            if (cnt_q[i] > 4'd1) begin
              cnt_d[i] = cnt_q[i] - 4'd1;
            end else begin
              state_d[i] = S_IDLE;
              x_d[i]     = 4'd0;
              y_d[i]     = 4'd0;
              cnt_d[i]   = 4'd0;
            end
          end
          default: ;
        endcase
      end
    end

    // Accepted slots were idle, so they never collide with the tick updates above.
    if (p1_accept) begin
      state_d[p1_slot] = S_FUSE;
      x_d[p1_slot]     = p1_x;
      y_d[p1_slot]     = p1_y;
      cnt_d[p1_slot]   = FUSE_CNT;
    end
    if (p2_accept) begin
      state_d[p2_slot] = S_FUSE;
      x_d[p2_slot]     = p2_x;
      y_d[p2_slot]     = p2_y;
      cnt_d[p2_slot]   = FUSE_CNT;
    end

    p1_lives_d = (p1_hit && (p1_lives_q != 2'd0)) ? p1_lives_q - 2'd1 : p1_lives_q;
    p2_lives_d = (p2_hit && (p2_lives_q != 2'd0)) ? p2_lives_q - 2'd1 : p2_lives_q;
    p1_ack_d   = p1_accept;
    p2_ack_d   = p2_accept;

    if (game_reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        state_d[i] = S_IDLE;
        x_d[i]     = 4'd0;
        y_d[i]     = 4'd0;
        cnt_d[i]   = 4'd0;
      end
      p1_lives_d = 2'd3;
      p2_lives_d = 2'd3;
      p1_ack_d   = 1'b0;
      p2_ack_d   = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        state_q[i] <= S_IDLE;
        x_q[i]     <= 4'd0;
        y_q[i]     <= 4'd0;
        cnt_q[i]   <= 4'd0;
      end
      p1_lives_q <= 2'd3;
      p2_lives_q <= 2'd3;
      p1_ack_q   <= 1'b0;
      p2_ack_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        state_q[i] <= state_d[i];
        x_q[i]     <= x_d[i];
        y_q[i]     <= y_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      p1_lives_q <= p1_lives_d;
      p2_lives_q <= p2_lives_d;
      p1_ack_q   <= p1_ack_d;
      p2_ack_q   <= p2_ack_d;
    end
  end

  // Drawing read port.
  always_comb begin
    bomb_active    = 1'b0;
    bomb_exploding = 1'b0;
    bomb_x         = 4'd0;
    bomb_y         = 4'd0;
    if (bomb_id < 3'd6) begin
      bomb_active    = (state_q[bomb_id] != S_IDLE);
      bomb_exploding = (state_q[bomb_id] == S_BLAST);
      bomb_x         = x_q[bomb_id];
      bomb_y         = y_q[bomb_id];
    end
  end

  assign p1_ack   = p1_ack_q;
  assign p2_ack   = p2_ack_q;
  assign p1_lives = p1_lives_q;
  assign p2_lives = p2_lives_q;

endmodule

// File: tb/tb_bomb_manager.sv
// Bench for bomb_manager with FUSE_TICKS=3, BLAST_TICKS=2, RADIUS=1.
// Reference model tracks each bomb by its age in ticks since placement.
module tb_bomb_manager;
  localparam int F = 3;
  localparam int B = 2;
  localparam int R = 1;

  logic       clock = 1'b0;
  logic       reset;
  logic       game_reset;
  logic       refresh;
  logic       p1_place;
  logic [3:0] p1_x;
  logic [3:0] p1_y;
  logic       p2_place;
  logic [3:0] p2_x;
  logic [3:0] p2_y;
  logic [2:0] bomb_id;
  logic       bomb_active;
  logic       bomb_exploding;
  logic [3:0] bomb_x;
  logic [3:0] bomb_y;
  logic       p1_ack;
  logic       p2_ack;
  logic [1:0] p1_lives;
  logic [1:0] p2_lives;

  int tests = 0;
  int fails = 0;

  bit m_used [6];
  int m_age  [6];
  int m_x    [6];
  int m_y    [6];
  int m_l1, m_l2;
  bit m_a1, m_a2;

  bomb_manager #(.FUSE_TICKS(F), .BLAST_TICKS(B), .RADIUS(R)) dut (
    .clock(clock), .reset(reset), .game_reset(game_reset), .refresh(refresh),
    .p1_place(p1_place), .p1_x(p1_x), .p1_y(p1_y),
    .p2_place(p2_place), .p2_x(p2_x), .p2_y(p2_y),
    .bomb_id(bomb_id), .bomb_active(bomb_active), .bomb_exploding(bomb_exploding),
    .bomb_x(bomb_x), .bomb_y(bomb_y), .p1_ack(p1_ack), .p2_ack(p2_ack),
    .p1_lives(p1_lives), .p2_lives(p2_lives)
  );

  always #20 clock = ~clock;

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic m_clear();
    for (int i = 0; i < 6; i++) begin
      m_used[i] = 1'b0;
      m_age[i]  = 0;
      m_x[i]    = 0;
      m_y[i]    = 0;
    end
    m_l1 = 3;
    m_l2 = 3;
    m_a1 = 1'b0;
    m_a2 = 1'b0;
  endtask

  function automatic bit m_cover(input int bx, input int by, input int tx, input int ty);
    return ((tx == bx) && (ty - by <= R) && (by - ty <= R)) ||
           ((ty == by) && (tx - bx <= R) && (bx - tx <= R));
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  task automatic m_update();
    bit frozen, tck, h1, h2, busy1, busy2, acc1, acc2;
    int s1, s2;
    if (game_reset) begin
      m_clear();
      return;
    end
    frozen = (m_l1 == 0) || (m_l2 == 0);
    tck    = refresh && !frozen;
    busy1  = 1'b0;
    busy2  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (m_used[i]) begin
        if (m_x[i] == int'(p1_x) && m_y[i] == int'(p1_y)) busy1 = 1'b1;
        if (m_x[i] == int'(p2_x) && m_y[i] == int'(p2_y)) busy2 = 1'b1;
      end
    end
    s1 = -1;
    for (int i = 0; i < 3; i++) if (!m_used[i] && s1 < 0) s1 = i;
    s2 = -1;
    for (int i = 3; i < 6; i++) if (!m_used[i] && s2 < 0) s2 = i;
    acc1 = p1_place && !frozen && (s1 >= 0) && !busy1;
    acc2 = p2_place && !frozen && (s2 >= 0) && !busy2 &&
           !(p1_place && p1_x == p2_x && p1_y == p2_y);
    h1 = 1'b0;
    h2 = 1'b0;
    if (tck) begin
      for (int i = 0; i < 6; i++) begin
        if (m_used[i]) begin
          m_age[i]++;
          if (m_age[i] == F) begin
            if (m_cover(m_x[i], m_y[i], p1_x, p1_y)) h1 = 1'b1;
            if (m_cover(m_x[i], m_y[i], p2_x, p2_y)) h2 = 1'b1;
          end
          if (m_age[i] == F + B) m_used[i] = 1'b0;
        end
      end
    end
    if (acc1) begin
      m_used[s1] = 1'b1; m_age[s1] = 0; m_x[s1] = p1_x; m_y[s1] = p1_y;
    end
    if (acc2) begin
      m_used[s2] = 1'b1; m_age[s2] = 0; m_x[s2] = p2_x; m_y[s2] = p2_y;
    end
    if (h1 && m_l1 > 0) m_l1--;
    if (h2 && m_l2 > 0) m_l2--;
    m_a1 = acc1;
    m_a2 = acc2;
  endtask

  // strict: idle slots must also read x=y=0 (after reset / game_reset).
  task automatic check_all(input bit strict);
    chk("p1_lives", p1_lives, m_l1);
    chk("p2_lives", p2_lives, m_l2);
    chk("p1_ack", p1_ack, m_a1);
    chk("p2_ack", p2_ack, m_a2);
    for (int id = 0; id < 8; id++) begin
      bit a, e;
      int ex, ey;
      a = 1'b0; e = 1'b0; ex = 0; ey = 0;
      if (id < 6) begin
        a = m_used[id];
        e = m_used[id] && (m_age[id] >= F);
        if (a) begin
          ex = m_x[id];
          ey = m_y[id];
        end
      end
      bomb_id = 3'(id);
      #1;
      chk($sformatf("active[%0d]", id), bomb_active, a);
      chk($sformatf("exploding[%0d]", id), bomb_exploding, e);
      if (a || id >= 6 || strict) begin
        chk($sformatf("x[%0d]", id), bomb_x, ex);
        chk($sformatf("y[%0d]", id), bomb_y, ey);
      end
    end
  endtask

  task automatic step(input bit g, input bit r, input bit pl1, input int x1, input int y1,
                      input bit pl2, input int x2, input int y2);
    game_reset = g;
    refresh    = r;
    p1_place   = pl1;
    p1_x       = 4'(x1);
    p1_y       = 4'(y1);
    p2_place   = pl2;
    p2_x       = 4'(x2);
    p2_y       = 4'(y2);
    m_update();
    @(posedge clock);
    #1;
    check_all(g);
    game_reset = 1'b0;
    refresh    = 1'b0;
    p1_place   = 1'b0;
    p2_place   = 1'b0;
  endtask

  task automatic t_tick(input int n);
    for (int k = 0; k < n; k++) step(0, 1, 0, p1_x, p1_y, 0, p2_x, p2_y);
  endtask

  task automatic rd(input int id);
    bomb_id = 3'(id);
    #1;
  endtask

  initial begin
    reset = 1'b1; game_reset = 1'b0; refresh = 1'b0;
    p1_place = 1'b0; p2_place = 1'b0;
    p1_x = 4'd0; p1_y = 4'd0; p2_x = 4'd15; p2_y = 4'd15; bomb_id = 3'd0;
    m_clear();
    #25;
    check_all(1);
    chk("reset p1_lives", p1_lives, 3);
    chk("reset p2_lives", p2_lives, 3);
    @(negedge clock);
    reset = 1'b0;

    // Fuse then blast timing on slot 0.
    step(0, 0, 1, 5, 5, 0, 15, 15);
    chk("first place ack", p1_ack, 1);
    step(0, 0, 0, 0, 0, 0, 15, 15);
    t_tick(2);
    rd(0); chk("slot0 fuse after 2 ticks", bomb_exploding, 0);
    t_tick(1);
    rd(0); chk("slot0 blast after 3 ticks", bomb_exploding, 1);
    chk("slot0 active in blast", bomb_active, 1);
    t_tick(2);
    rd(0); chk("slot0 idle after blast", bomb_active, 0);

    // Three P1 slots, fourth rejected, occupied tile rejected.
    step(0, 0, 1, 1, 1, 0, 15, 15); chk("p1 place 1", p1_ack, 1);
    step(0, 0, 1, 3, 1, 0, 15, 15); chk("p1 place 2", p1_ack, 1);
    step(0, 0, 1, 5, 1, 0, 15, 15); chk("p1 place 3", p1_ack, 1);
    step(0, 0, 1, 7, 1, 0, 15, 15); chk("p1 place 4 full", p1_ack, 0);
    step(0, 0, 0, 7, 1, 1, 1, 1);   chk("p2 occupied tile", p2_ack, 0);
    step(0, 0, 0, 0, 0, 0, 15, 15);
    t_tick(5);

    // Blast reaches P2 at distance 1, misses P1 at distance 2.
    step(0, 0, 1, 5, 5, 0, 15, 15);
    step(0, 0, 0, 5, 7, 0, 6, 5);
    t_tick(3);
    chk("p2 hit", p2_lives, 2);
    chk("p1 out of range", p1_lives, 3);
    t_tick(2);

    // Two simultaneous blasts over P1 cost one life.
    step(0, 0, 1, 2, 3, 1, 4, 3);
    step(0, 0, 0, 3, 3, 0, 10, 10);
    t_tick(3);
    chk("double hit single life", p1_lives, 2);
    t_tick(2);

    // Same tile same cycle: P1 wins.
    step(0, 0, 1, 7, 7, 1, 7, 7);
    chk("tie p1 ack", p1_ack, 1);
    chk("tie p2 ack", p2_ack, 0);
    step(0, 0, 0, 0, 0, 0, 15, 15);
    t_tick(5);

    // Drive P2 to zero, then everything freezes.
    for (int n = 0; n < 2; n++) begin
      step(0, 0, 1, 8, 8, 0, 15, 15);
      step(0, 0, 0, 0, 0, 0, 8, 9);
      t_tick(3);
      if (n == 0) t_tick(2);
    end
    chk("p2 dead", p2_lives, 0);
    step(0, 0, 1, 1, 1, 1, 12, 12);
    chk("frozen p1 place", p1_ack, 0);
    chk("frozen p2 place", p2_ack, 0);
    t_tick(3);
    rd(0); chk("frozen blast held", bomb_exploding, 1);
    chk("frozen p1 lives", p1_lives, 2);
    step(1, 1, 1, 1, 1, 1, 9, 9);
    chk("game_reset p1_lives", p1_lives, 3);
    chk("game_reset p2_lives", p2_lives, 3);

    // Place in the tick cycle: full fuse still to run.
    step(0, 1, 1, 9, 9, 0, 15, 15);
    step(0, 0, 0, 0, 0, 0, 15, 15);
    t_tick(2);
    rd(0); chk("place+tick fuse left", bomb_exploding, 0);
    t_tick(1);
    rd(0); chk("place+tick detonates", bomb_exploding, 1);

    // Asynchronous reset in the middle of a blast.
    @(negedge clock);
    reset = 1'b1;
    m_clear();
    #1;
    check_all(1);
    @(negedge clock);
    reset = 1'b0;

    // Random traffic in a small arena to provoke collisions and damage.
    for (int c = 0; c < 600; c++) begin
      step($urandom_range(0, 59) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 4), $urandom_range(0, 4),
           $urandom_range(0, 2) == 0, $urandom_range(0, 4), $urandom_range(0, 4));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
